lsu_remote_req_queue: RTL and testbench

// - Decouples LSU remote requests (icache fetch, remote load/store, AMO, CBO) from the network TX endpoint.
// - Sits between the LSU (remote_req_o / remote_req_v_o) and the TX link.
// - Buffers requests in a small FIFO and enforces an outstanding-request credit limit.
// - Drives a ready that EXE uses as its remote-request stall.
//

---
 rtl/lsu_remote_req_queue_pkg.sv | 22 ++
 rtl/lsu_credit_counter.sv | 40 ++++
 rtl/lsu_remote_req_queue.sv | 125 ++++++++++++
 tb/tb_lsu_remote_req_queue.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_remote_req_queue_pkg.sv
// Shared types and default sizing for the LSU remote-request path.
//
// Contents:
//   remote_req_s            request as issued by the LSU toward the network TX endpoint
//   lsu_remote_req_els_gp   default queue depth
//   lsu_max_out_credits_gp  default limit on queued + in-flight requests
package lsu_remote_req_queue_pkg;

  localparam int unsigned lsu_remote_req_els_gp  = 2;
  localparam int unsigned lsu_max_out_credits_gp = 32;

  typedef struct packed {
    logic        write_not_read;
    logic        is_amo_op;
    logic [3:0]  amo_type;
    logic [3:0]  mask;
    logic [4:0]  reg_id;
    logic [31:0] payload;
    logic [31:0] addr;
  } remote_req_s;

endpackage

// File: rtl/lsu_credit_counter.sv
// Up/down counter for outstanding-request tracking.
//
// Ports:
//   clk_i      clock
//   reset_n_i  asynchronous active-low reset, clears the count
//   inc_i      add one this cycle
//   dec_i      subtract one this cycle (inc_i & dec_i together cancel)
//   count_o    current count (registered)
module lsu_credit_counter #(
  parameter int unsigned Width = 6
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    unique case ({inc_i, dec_i})
      2'b10:   count_d = count_q + Width'(1);
      2'b01:   count_d = count_q - Width'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/lsu_remote_req_queue.sv
// FIFO between the LSU and the network TX endpoint with an outstanding-request credit limit.
//
// Ports:
//   clk_i               clock
//   reset_n_i           asynchronous active-low reset
//   remote_req_i        request from the LSU
//   remote_req_v_i      request valid
//   remote_req_ready_o  queue can accept (registered-state only; EXE stall source)
//   remote_req_o        head-of-queue request
//   remote_req_v_o      head valid
//   remote_req_yumi_i   TX consumed the head this cycle
//   credit_return_i     one response returned from the network
//   out_credits_used_o  queued + issued-but-unanswered requests
//   all_idle_o          nothing queued and nothing outstanding
module lsu_remote_req_queue
  import lsu_remote_req_queue_pkg::*;
#(
  parameter int unsigned els_p             = lsu_remote_req_els_gp,
  parameter int unsigned max_out_credits_p = lsu_max_out_credits_gp,
  localparam int unsigned credit_w_lp      = $clog2(max_out_credits_p + 1)
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  remote_req_s            remote_req_i,
  input  logic                   remote_req_v_i,
  output logic                   remote_req_ready_o,
  output remote_req_s            remote_req_o,
  output logic                   remote_req_v_o,
  input  logic                   remote_req_yumi_i,
  input  logic                   credit_return_i,
  output logic [credit_w_lp-1:0] out_credits_used_o,
  output logic                   all_idle_o
);

  localparam int unsigned PtrW = $clog2(els_p);
  localparam int unsigned CntW = $clog2(els_p + 1);
  // One spare bit so count + outstanding cannot wrap before the compare.
  localparam int unsigned SumW = ((CntW > credit_w_lp) ? CntW : credit_w_lp) + 1;

  remote_req_s mem_q [els_p];

  logic [PtrW-1:0]        wr_ptr_d, wr_ptr_q;
  logic [PtrW-1:0]        rd_ptr_d, rd_ptr_q;
  logic [CntW-1:0]        count_d, count_q;
  logic [credit_w_lp-1:0] outstanding;
  logic [SumW-1:0]        used_sum;
  logic                   enq, deq;

  assign enq = remote_req_v_i & remote_req_ready_o;
  assign deq = remote_req_yumi_i;

  assign used_sum = SumW'(count_q) + SumW'(outstanding);

  assign remote_req_ready_o = (count_q != CntW'(els_p)) &&
                              (used_sum < SumW'(max_out_credits_p));
  assign remote_req_v_o     = (count_q != '0);
  assign remote_req_o       = mem_q[rd_ptr_q];
  assign out_credits_used_o = credit_w_lp'(used_sum);
  assign all_idle_o         = (count_q == '0) && (outstanding == '0);

  // Pointers are log2(els_p) wide so the increment wraps on its own.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (deq) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({enq, deq})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; count_q alone decides which entries are live.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem_q[wr_ptr_q] <= remote_req_i;
    end
  end

  // A dequeued request becomes outstanding until its response returns.
  lsu_credit_counter #(
    .Width (credit_w_lp)
  ) u_out_cnt (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .inc_i     (deq),
    .dec_i     (credit_return_i),
    .count_o   (outstanding)
  );

`ifndef SYNTHESIS
  always @(negedge clk_i) begin
    if (reset_n_i) begin
      assert (!(remote_req_yumi_i && !remote_req_v_o))
        else $error("lsu_remote_req_queue: yumi while head not valid");
      assert (!(credit_return_i && (outstanding == '0) && !remote_req_yumi_i))
        else $error("lsu_remote_req_queue: credit return with nothing outstanding");
      assert (!(remote_req_v_i && remote_req_ready_o && (count_q == CntW'(els_p))))
        else $error("lsu_remote_req_queue: enqueue while full");
      assert (!(remote_req_yumi_i && !credit_return_i &&
                (outstanding == credit_w_lp'(max_out_credits_p))))
        else $error("lsu_remote_req_queue: outstanding counter overflow");
    end
  end
`endif

endmodule

// File: tb/tb_lsu_remote_req_queue.sv
module tb_lsu_remote_req_queue;
  import lsu_remote_req_queue_pkg::*;

  localparam int unsigned Els   = 2;
  localparam int unsigned MaxCr = 4;
  localparam int unsigned CrW   = $clog2(MaxCr + 1);

  logic           clk = 1'b0;
  logic           reset_n;
  remote_req_s    req_i, req_o, hold;
  logic           v_i, ready_o, v_o, yumi, credit;
  logic [CrW-1:0] used;
  logic           idle;

  int tests_run    = 0;
  int tests_failed = 0;
  remote_req_s sb[$];

  always #5 clk = ~clk;

  lsu_remote_req_queue #(
    .els_p             (Els),
    .max_out_credits_p (MaxCr)
  ) dut (
    .clk_i              (clk),
    .reset_n_i          (reset_n),
    .remote_req_i       (req_i),
    .remote_req_v_i     (v_i),
    .remote_req_ready_o (ready_o),
    .remote_req_o       (req_o),
    .remote_req_v_o     (v_o),
    .remote_req_yumi_i  (yumi),
    .credit_return_i    (credit),
    .out_credits_used_o (used),
    .all_idle_o         (idle)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_req(input string tag, input remote_req_s obs, input remote_req_s exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic remote_req_s mk(input int n);
    remote_req_s r;
    r.write_not_read = n[0];
    r.is_amo_op      = n[1];
    r.amo_type       = n[5:2];
    r.mask           = 4'hf ^ n[3:0];
    r.reg_id         = n[4:0] + 5'd3;
    r.payload        = 32'hA5A5_0000 ^ (n * 32'h0101_0101);
    r.addr           = 32'h0000_1000 + (n * 4);
    return r;
  endfunction

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: push on accepted enqueue, pop and compare on every TX handshake.
  always @(negedge clk) begin
    if (!reset_n) begin
      sb.delete();
    end else begin
      if (v_o && yumi) begin
        if (sb.size() == 0) chk("sb_underflow", 32'(sb.size()), 32'd1);
        else chk_req("sb_order", req_o, sb.pop_front());
      end
      if (v_i && ready_o) sb.push_back(req_i);
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    req_i   = '0;
    v_i     = 1'b0;
    yumi    = 1'b0;
    credit  = 1'b0;
    next();
    @(negedge clk);
    chk("rst_v_o", 32'(v_o), 32'd0);
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_used", 32'(used), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    next();
    reset_n = 1'b1;

    // Reset mid-stream with two entries queued.
    v_i = 1'b1; req_i = mk(0);
    @(negedge clk); next();
    req_i = mk(1);
    @(negedge clk); next();
    v_i = 1'b0;
    @(negedge clk);
    chk("pre_rst_v_o", 32'(v_o), 32'd1);
    chk("pre_rst_used", 32'(used), 32'd2);
    chk("pre_rst_ready", 32'(ready_o), 32'd0);
    next();
    #3 reset_n = 1'b0;
    #1;
    chk("async_rst_v_o", 32'(v_o), 32'd0);
    chk("async_rst_ready", 32'(ready_o), 32'd1);
    chk("async_rst_used", 32'(used), 32'd0);
    chk("async_rst_idle", 32'(idle), 32'd1);
    next(); next();
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_v_o", 32'(v_o), 32'd0);
    chk("post_rst_ready", 32'(ready_o), 32'd1);
    chk("post_rst_used", 32'(used), 32'd0);
    chk("post_rst_idle", 32'(idle), 32'd1);
    next();

    // Back-to-back A,B,C with TX consuming every valid cycle.
    v_i = 1'b1; req_i = mk(10); yumi = 1'b0;
    @(negedge clk);
    chk("b2b_no_bypass", 32'(v_o), 32'd0);
    next();
    req_i = mk(11); yumi = 1'b1;
    @(negedge clk);
    chk("b2b_head_a_v", 32'(v_o), 32'd1);
    next();
    req_i = mk(12);
    @(negedge clk);
    chk("b2b_head_b_v", 32'(v_o), 32'd1);
    next();
    v_i = 1'b0;
    @(negedge clk);
    chk("b2b_head_c_v", 32'(v_o), 32'd1);
    next();
    yumi = 1'b0;
    @(negedge clk);
    chk("b2b_used3", 32'(used), 32'd3);
    chk("b2b_empty", 32'(v_o), 32'd0);
    credit = 1'b1;
    repeat (3) begin
      next();
    end
    credit = 1'b0;
    @(negedge clk);
    chk("b2b_returned_used", 32'(used), 32'd0);
    chk("b2b_returned_idle", 32'(idle), 32'd1);
    next();

    // Full queue holds its head stable.
    v_i = 1'b1; req_i = mk(20);
    @(negedge clk); next();
    req_i = mk(21);
    @(negedge clk); next();
    v_i = 1'b0;
    hold = mk(20);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("full_ready", 32'(ready_o), 32'd0);
      chk("full_v_o", 32'(v_o), 32'd1);
      chk_req("full_hold", req_o, hold);
      next();
    end
    yumi = 1'b1;
    @(negedge clk);
    chk("full_yumi_ready", 32'(ready_o), 32'd0);
    next();
    yumi = 1'b0;
    @(negedge clk);
    chk("full_after_ready", 32'(ready_o), 32'd1);
    chk_req("full_head_b", req_o, mk(21));
    next();
    yumi = 1'b1;
    @(negedge clk); next();
    yumi = 1'b0; credit = 1'b1;
    @(negedge clk); next();
    @(negedge clk); next();
    credit = 1'b0;
    @(negedge clk);
    chk("full_drained_idle", 32'(idle), 32'd1);
    next();

    // Credit limit: four issued with no responses.
    v_i = 1'b1; req_i = mk(30);
    @(negedge clk); next();
    req_i = mk(31); yumi = 1'b1;
    @(negedge clk); next();
    req_i = mk(32);
    @(negedge clk); next();
    req_i = mk(33);
    @(negedge clk);
    chk("lim_ready_at3", 32'(ready_o), 32'd1);
    next();
    v_i = 1'b0;
    @(negedge clk);
    chk("lim_ready_q1_o3", 32'(ready_o), 32'd0);
    next();
    yumi = 1'b0;
    @(negedge clk);
    chk("lim_ready", 32'(ready_o), 32'd0);
    chk("lim_used4", 32'(used), 32'd4);
    next();
    credit = 1'b1;
    @(negedge clk);
    chk("lim_ret_same_cycle", 32'(ready_o), 32'd0);
    next();
    credit = 1'b0;
    @(negedge clk);
    chk("lim_ret_ready", 32'(ready_o), 32'd1);
    chk("lim_ret_used", 32'(used), 32'd3);
    next();

    // Same-cycle yumi + credit return at outstanding=3, count=1.
    v_i = 1'b1; req_i = mk(40);
    @(negedge clk); next();
    v_i = 1'b0; yumi = 1'b1; credit = 1'b1;
    @(negedge clk);
    chk("sim_pre_used", 32'(used), 32'd4);
    chk("sim_pre_ready", 32'(ready_o), 32'd0);
    next();
    yumi = 1'b0; credit = 1'b0;
    @(negedge clk);
    chk("sim_used", 32'(used), 32'd3);
    chk("sim_v_o", 32'(v_o), 32'd0);
    chk("sim_ready", 32'(ready_o), 32'd1);
    next();

    // Drain: idle exactly one cycle after the last response.
    credit = 1'b1;
    @(negedge clk); next();
    @(negedge clk); next();
    @(negedge clk);
    chk("drain_last_ret_idle", 32'(idle), 32'd0);
    next();
    credit = 1'b0;
    @(negedge clk);
    chk("drain_idle", 32'(idle), 32'd1);
    chk("drain_used", 32'(used), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
